// File: rtl/bpf_serial_rx.sv
// rtl/bpf_serial_rx.sv - Oversampling receiver for the 3-wire band-filter control bus.
module bpf_serial_rx #(
    parameter int         WORD_BITS = 16,
    parameter logic [3:0] ADDR      = 4'hA,
    parameter int         TIMEOUT   = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ser_data,
    input  logic       ser_clk,
    input  logic       ser_en,
    output logic [2:0] bpf_sel,
    output logic       vhf_en,
    output logic [7:0] aux,
    output logic       word_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(WORD_BITS + 2);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_ERR,
        ST_WAIT_EN_LOW
    } state_t;

    state_t                 state;
    logic [1:0]             data_sync;
    logic [2:0]             clk_sync;
    logic [2:0]             en_sync;
    logic [WORD_BITS-1:0]   shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [TMO_W-1:0]       tmo_cnt;

    logic clk_rise;
    logic en_rise;
    logic en_fall;
    logic en_level;
    logic bit_in;

    // Index 1 is the synchronized level, index 2 the previous value for edge detection.
    assign clk_rise = clk_sync[1] & ~clk_sync[2];
    assign en_rise  = en_sync[1] & ~en_sync[2];
    assign en_fall  = ~en_sync[1] & en_sync[2];
    assign en_level = en_sync[1];
    assign bit_in   = data_sync[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            data_sync <= '0;
            clk_sync  <= '0;
            en_sync   <= '0;
        end else begin
            data_sync <= {data_sync[0], ser_data};
            clk_sync  <= {clk_sync[1:0], ser_clk};
            en_sync   <= {en_sync[1:0], ser_en};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            bpf_sel    <= 3'd7;
            vhf_en     <= 1'b0;
            aux        <= 8'h00;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en_rise) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        tmo_cnt   <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // End of frame beats a coincident clock edge; that bit is dropped.
                    if (en_fall) begin
                        state <= ST_CHECK;
                    end else if (clk_rise) begin
                        shift_reg <= {shift_reg[WORD_BITS-2:0], bit_in};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= ST_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (bit_cnt == CNT_FULL && shift_reg[WORD_BITS-1 -: 4] == ADDR) begin
                        aux        <= shift_reg[11:4];
                        vhf_en     <= shift_reg[3];
                        bpf_sel    <= shift_reg[2:0];
                        word_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        state <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    frame_err <= 1'b1;
                    state     <= en_level ? ST_WAIT_EN_LOW : ST_IDLE;
                end
                ST_WAIT_EN_LOW: begin
                    if (!en_level) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
